// File: rtl/pht_predictor.sv
// Pattern-history-table branch predictor: 2-bit saturating counters indexed by
// {PC_ROW, column}, with an in-order queue of in-flight branches for training.
module pht_predictor #(
    parameter int HIST_W = 4,
    parameter int ROW_W  = 2,
    parameter int QDEPTH = 4
) (
    input  logic              CLOCK,
    input  logic              INIT,
    input  logic [HIST_W-1:0] column,
    input  logic [ROW_W-1:0]  PC_ROW,
    input  logic              PREDICT_REQ,
    output logic              PRED_VALID,
    output logic              PREDICTION,
    input  logic              RESOLVE,
    input  logic              OUTCOME,
    output logic              MISPREDICT,
    output logic              STALL
);

    localparam int IDX_W = ROW_W + HIST_W;
    localparam int TBL_N = 1 << IDX_W;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
            else              res = ctr;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
            else              res = ctr;
        end
        return res;
    endfunction

    logic [1:0]       table_q [TBL_N];
    logic [IDX_W-1:0] q_idx_q [QDEPTH];
    logic             q_pred_q[QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] req_idx_s, head_idx_s;
    logic             head_pred_s, pop_s, push_s, req_pred_s;
    logic [1:0]       new_ctr_s;

    // Accept/pop decisions, head-of-queue training value and next occupancy.
    always_comb begin
        req_idx_s   = {PC_ROW, column};
        req_pred_s  = table_q[req_idx_s][1];
        pop_s       = RESOLVE && (count_q != CNT_ZERO);
        push_s      = PREDICT_REQ && ((count_q != CNT_FULL) || pop_s);
        head_idx_s  = q_idx_q[rd_ptr_q];
        head_pred_s = q_pred_q[rd_ptr_q];
        new_ctr_s   = sat_update(table_q[head_idx_s], OUTCOME);
        count_d     = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Table training, queue bookkeeping and registered outputs; the prediction
    // reads the table before this edge's update lands (read-before-write).
    always_ff @(posedge CLOCK) begin
        if (INIT) begin
            for (int i = 0; i < TBL_N; i++) table_q[i] <= 2'b01;
            for (int j = 0; j < QDEPTH; j++) begin
                q_idx_q[j]  <= {IDX_W{1'b0}};
                q_pred_q[j] <= 1'b0;
            end
            rd_ptr_q   <= PTR_ZERO;
            wr_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            PRED_VALID <= 1'b0;
            PREDICTION <= 1'b0;
            MISPREDICT <= 1'b0;
            STALL      <= 1'b0;
        end else begin
            if (pop_s) begin
                table_q[head_idx_s] <= new_ctr_s;
                rd_ptr_q            <= rd_ptr_q + PTR_ONE;
            end
            if (push_s) begin
                q_idx_q[wr_ptr_q]  <= req_idx_s;
                q_pred_q[wr_ptr_q] <= req_pred_s;
                wr_ptr_q           <= wr_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            PRED_VALID <= push_s;
            PREDICTION <= push_s ? req_pred_s : 1'b0;
            MISPREDICT <= pop_s && (OUTCOME != head_pred_s);
            STALL      <= (count_d == CNT_FULL);
        end
    end

endmodule

// File: tb/tb_pht_predictor.sv
// Scoreboard bench for pht_predictor: directed scenarios then random traffic,
// checked against an abstract counter-table and branch-queue model.
module tb_pht_predictor;

    logic       CLOCK = 1'b0;
    logic       INIT = 1'b0;
    logic [3:0] column = 4'd0;
    logic [1:0] PC_ROW = 2'd0;
    logic       PREDICT_REQ = 1'b0;
    logic       RESOLVE = 1'b0;
    logic       OUTCOME = 1'b0;
    logic       PRED_VALID, PREDICTION, MISPREDICT, STALL;

    pht_predictor #(.HIST_W(4), .ROW_W(2), .QDEPTH(4)) dut (
        .CLOCK(CLOCK), .INIT(INIT), .column(column), .PC_ROW(PC_ROW),
        .PREDICT_REQ(PREDICT_REQ), .PRED_VALID(PRED_VALID), .PREDICTION(PREDICTION),
        .RESOLVE(RESOLVE), .OUTCOME(OUTCOME), .MISPREDICT(MISPREDICT), .STALL(STALL)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct { bit pv; bit pred; bit misp; bit stall; } exp_t;
    typedef struct { int idx; bit pred; } inflight_t;

    exp_t      exp_q[$];
    inflight_t model_q[$];
    int        model_ctr[64];
    int        checks = 0;
    int        passes = 0;
    bit        last_accepted;

    // Reference: the table is 64 integer counters 0..3, the queue a list of branches.
    task automatic cycle(input bit init, input bit req, input int idx, input bit res, input bit outc);
        exp_t e;
        bit   pop, push, pred;
        inflight_t h;
        INIT        = init;
        PREDICT_REQ = req;
        PC_ROW      = 2'(idx >> 4);
        column      = 4'(idx & 15);
        RESOLVE     = res;
        OUTCOME     = outc;
        e = '{pv: 1'b0, pred: 1'b0, misp: 1'b0, stall: 1'b0};
        if (init) begin
            foreach (model_ctr[k]) model_ctr[k] = 1;
            model_q.delete();
            last_accepted = 1'b0;
        end else begin
            pop  = res && (model_q.size() > 0);
            push = req && (model_q.size() < 4 || pop);
            pred = (model_ctr[idx] >= 2);
            if (pop) begin
                h = model_q.pop_front();
                e.misp = (outc != h.pred);
                if (outc) model_ctr[h.idx] = (model_ctr[h.idx] < 3) ? model_ctr[h.idx] + 1 : 3;
                else      model_ctr[h.idx] = (model_ctr[h.idx] > 0) ? model_ctr[h.idx] - 1 : 0;
            end
            if (push) model_q.push_back('{idx: idx, pred: pred});
            e.pv          = push;
            e.pred        = push && pred;
            e.stall       = (model_q.size() == 4);
            last_accepted = push;
        end
        exp_q.push_back(e);
        @(posedge CLOCK);
        #2;
    endtask

    task automatic check(input string name, input logic act, input bit req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
    endtask

    // Monitor: one expectation per clocked cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred_valid", PRED_VALID, e.pv);
                if (e.pv) check("prediction", PREDICTION, e.pred);
                check("mispredict", MISPREDICT, e.misp);
                check("stall", STALL, e.stall);
            end
        end
    end

    initial begin
        int ridx;
        bit rreq, hold;
        last_accepted = 1'b0;
        #2;
        // 1: reset then first prediction
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        // 2: train idx 5 twice taken, then predict
        for (int r = 0; r < 2; r++) begin
            cycle(0, 1, 5, 0, 0);
            cycle(0, 0, 0, 1, 1);
        end
        cycle(0, 1, 5, 0, 0);
        cycle(0, 0, 0, 1, 1);
        // 3: saturation on idx 9
        for (int r = 0; r < 4; r++) begin
            cycle(0, 1, 9, 0, 0);
            cycle(0, 0, 0, 1, 1);
        end
        cycle(0, 1, 9, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 9, 0, 0);
        cycle(0, 0, 0, 1, 1);
        // 4: mispredict on fresh idx 0x2A, then correct prediction
        cycle(0, 1, 42, 0, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 42, 0, 0);
        cycle(0, 0, 0, 1, 1);
        // 5: fill, rejected fifth, then fifth with simultaneous resolve, drain
        for (int r = 0; r < 4; r++) cycle(0, 1, 16 + r, 0, 0);
        cycle(0, 1, 20, 0, 0);
        cycle(0, 1, 20, 1, 1);
        for (int r = 0; r < 5; r++) cycle(0, 0, 0, 1, r[0]);
        // 6: empty resolve, INIT with branches in flight, sweep every counter
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 5, 0, 0);
        cycle(0, 1, 9, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) cycle(0, 1, i, (i > 0), 1'b0);
        cycle(0, 0, 0, 1, 0);
        // Random traffic; a rejected request is held until accepted
        hold = 1'b0;
        ridx = 0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                rreq = ($urandom_range(0, 3) != 0);
                ridx = $urandom_range(0, 63);
            end
            cycle(($urandom_range(0, 149) == 0), rreq, ridx,
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 1));
            hold = rreq && !last_accepted && !INIT;
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        @(negedge CLOCK);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
